reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter.sv | 84 ++++++++
 tb/tb_reg_wb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin writeback arbiter for two register-file writers
// Optional pending-write scoreboard and hazard output built only with WB_HAZARD_EN.
module reg_wb_arbiter #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_gnt,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_gnt,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] chk_r1,
    input  logic [AW-1:0] chk_r2,
    output logic          hazard,
    output logic [AW-1:0] wr,
    output logic [DW-1:0] wd,
    output logic          regwrt
);
    localparam int NR = 1 << AW;

    // Set once A wins, so B takes the next tie; cleared once B wins.
    logic prio_b;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (a_req && (!b_req || !prio_b))
                a_gnt = 1'b1;
            else if (b_req)
                b_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b <= 1'b0;
            regwrt <= 1'b0;
            wr     <= '0;
            wd     <= '0;
        end else begin
            regwrt <= a_gnt | b_gnt;
            if (a_gnt) begin
                wr     <= a_addr;
                wd     <= a_data;
                prio_b <= 1'b1;
            end else if (b_gnt) begin
                wr     <= b_addr;
                wd     <= b_data;
                prio_b <= 1'b0;
            end
        end
    end

`ifdef WB_HAZARD_EN
    logic [NR-1:0] busy;

    // The set is written last so a same-address reservation outlives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (regwrt)
                busy[wr] <= 1'b0;
            if (rsv_valid)
                busy[rsv_addr] <= 1'b1;
        end
    end

    assign hazard = busy[chk_r1] | busy[chk_r2];
`else
    logic unused_hz;
    assign unused_hz = ^{rsv_valid, rsv_addr, chk_r1, chk_r2, NR[0]};
    assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - randomized and directed bench for reg_wb_arbiter against a reference model
module tb_reg_wb_arbiter;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 16;
`ifdef WB_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, b_req, a_gnt, b_gnt;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr, chk_r1, chk_r2;
    logic          hazard;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic          regwrt;

    reg_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .chk_r1(chk_r1), .chk_r2(chk_r2), .hazard(hazard),
        .wr(wr), .wd(wd), .regwrt(regwrt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file as seen by a consumer writing on the falling edge.
    logic [DW-1:0] rf [NR];
    always @(negedge clk) if (regwrt === 1'b1) rf[wr] = wd;

    // Reference model: who won last, pending-write set, and the expected write port.
    int            last_winner;   // 0 = A, 1 = B
    bit            m_busy [NR];
    bit            m_regwrt;
    logic [AW-1:0] m_wr;
    logic [DW-1:0] m_wd;

    task automatic model_reset();
        last_winner = 1;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_regwrt = 1'b0;
        m_wr = '0;
        m_wd = '0;
    endtask

    // One clock: check grants/hazard on the settled inputs, clock, then check the write port.
    task automatic step(output bit ga, output bit gb);
        bit ea, eb, eh;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                ea = (last_winner == 1);
                eb = !ea;
            end else begin
                ea = a_req;
                eb = b_req;
            end
        end
        eh = HZ && (m_busy[chk_r1] || m_busy[chk_r2]);
        check("a_gnt", a_gnt, ea);
        check("b_gnt", b_gnt, eb);
        check("hazard", hazard, eh);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_regwrt) m_busy[m_wr] = 1'b0;
            if (rsv_valid) m_busy[rsv_addr] = 1'b1;
            m_regwrt = ea || eb;
            if (ea) begin
                m_wr = a_addr; m_wd = a_data; last_winner = 0;
            end else if (eb) begin
                m_wr = b_addr; m_wd = b_data; last_winner = 1;
            end
        end
        #1;
        check("regwrt", regwrt, m_regwrt);
        check("wr", wr, m_wr);
        check("wd", wd, m_wd);
        ga = ea;
        gb = eb;
    endtask

    task automatic idle_inputs();
        a_req = 0; b_req = 0; a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
        rsv_valid = 0; rsv_addr = 0; chk_r1 = 0; chk_r2 = 0;
    endtask

    initial begin
        bit ga, gb;
        idle_inputs();
        model_reset();
        rst = 1;
        @(posedge clk); #1;
        step(ga, gb);
        rst = 0;

        // Single requester A
        a_req = 1; a_addr = 4'd3; a_data = 16'h0003;
        step(ga, gb);
        check("single_a_gnt", ga, 1);
        a_req = 0;
        step(ga, gb);
        check("single_a_wr", wr, 3);

        // Both requesting after reset: A,B,A,B
        rst = 1; step(ga, gb); rst = 0;
        for (int i = 0; i < 4; i++) begin
            a_req = 1; b_req = 1;
            a_addr = AW'(i); b_addr = AW'(i + 8);
            a_data = DW'(16'h100 + i); b_data = DW'(16'h200 + i);
            step(ga, gb);
            check("rr_a", ga, (i % 2) == 0);
            check("rr_b", gb, (i % 2) == 1);
            if (ga) a_req = 0;
            if (gb) b_req = 0;
        end
        a_req = 0; b_req = 0;
        step(ga, gb);

        // Same address from both writers: later grant wins
        a_req = 1; b_req = 1; a_addr = 4'd5; b_addr = 4'd5;
        a_data = 16'h00AA; b_data = 16'h00BB;
        for (int i = 0; i < 2; i++) begin
            step(ga, gb);
            if (ga) a_req = 0;
            if (gb) b_req = 0;
        end
        step(ga, gb);
        @(negedge clk); #1;
        check("same_addr_final", rf[5], 16'h00BB);

        // Reservation of r15, hazard, then cleared by a write to r15
        rsv_valid = 1; rsv_addr = 4'hF; chk_r1 = 4'hF;
        step(ga, gb);
        rsv_valid = 0;
        step(ga, gb);
        check("rsv15_hazard", hazard, HZ);
        a_req = 1; a_addr = 4'hF; a_data = 16'h1234;
        step(ga, gb);
        a_req = 0;
        step(ga, gb);
        step(ga, gb);
        check("rsv15_cleared", hazard, 0);
        chk_r1 = 0;

        // Reset in the transfer cycle drops the write
        a_req = 1; a_addr = 4'd7; a_data = 16'hDEAD; rst = 1;
        rsv_valid = 1; rsv_addr = 4'd7;
        step(ga, gb);
        check("rst_drop_regwrt", regwrt, 0);
        rst = 0; a_req = 0; rsv_valid = 0;
        for (int r = 0; r < NR; r++) begin
            chk_r1 = AW'(r); chk_r2 = AW'(r);
            #1;
            check("rst_busy_clear", hazard, 0);
        end

        // Reserve r2 and probe it
        rsv_valid = 1; rsv_addr = 4'd2; chk_r1 = 4'd2; chk_r2 = 4'd9;
        step(ga, gb);
        rsv_valid = 0;
        step(ga, gb);
        check("rsv2_hazard", hazard, HZ);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (!a_req && $urandom_range(0, 1) == 1) begin
                a_req = 1; a_addr = AW'($urandom); a_data = DW'($urandom);
            end
            if (!b_req && $urandom_range(0, 1) == 1) begin
                b_req = 1; b_addr = AW'($urandom); b_data = DW'($urandom);
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom);
            chk_r1 = AW'($urandom);
            chk_r2 = AW'($urandom);
            step(ga, gb);
            if (ga) a_req = 0;
            if (gb) b_req = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
